// File: rtl/arbiter_n_to_1_request.sv
// Round-robin concentrator: per-requestor 2-entry holding buffers feed one
// fair grant per cycle into a 32-deep FWFT output FIFO.
package arbiter_n_to_1_request_pkg;
  typedef struct packed {
    logic [7:0] from;
    logic [7:0] to;
  } MemoryRoute;

  typedef struct packed {
    MemoryRoute  route;
    logic [3:0]  cmd;
    logic [31:0] address;
  } MemoryMeta;

  typedef struct packed {
    MemoryMeta   meta;
    logic [31:0] data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic prog_full;
    logic empty;
  } FIFOStateSignalsOutput;
endpackage

module arbiter_n_to_1_request
  import arbiter_n_to_1_request_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int BUFFER_DEPTH         = 2,
  parameter int FIFO_WRITE_DEPTH     = 32,
  parameter int PROG_THRESH          = 16
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  MemoryPacket                     request_in [NUM_MEMORY_REQUESTOR],
  output logic [NUM_MEMORY_REQUESTOR-1:0] request_ready_out,
  input  FIFOStateSignalsInput            fifo_request_signals_in,
  output FIFOStateSignalsOutput           fifo_request_signals_out,
  output MemoryPacket                     request_out,
  output logic                            fifo_setup_signal
);
  localparam int N     = NUM_MEMORY_REQUESTOR;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = $clog2(FIFO_WRITE_DEPTH);
  localparam logic [1:0]  BUF_FULL   = 2'(BUFFER_DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH  = (AW+1)'(FIFO_WRITE_DEPTH);
  localparam logic [AW:0] CNT_THRESH = (AW+1)'(PROG_THRESH);

  logic [N-1:0]       eligible;
  logic [N-1:0]       pop_buf;
  MemoryPacketPayload head_payload [N];
  logic [IDX_W-1:0]   last_reg;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               grant_en;
  int                 cand_idx;
  logic               grant_valid_reg;
  MemoryPacketPayload grant_payload_reg;
  logic [1:0]         rst_sync_reg;
  logic               srst;
  logic               fifo_setup_reg;
  MemoryPacketPayload fifo_mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0]      fifo_wr_ptr_reg;
  logic [AW-1:0]      fifo_rd_ptr_reg;
  logic [AW:0]        fifo_count_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_prog_full;
  logic               fifo_wr;
  logic               fifo_pop;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
      MemoryPacketPayload mem_reg [2];
      logic [1:0]         cnt_reg;
      logic               wr_ptr_reg;
      logic               rd_ptr_reg;
      logic               push;

      assign request_ready_out[gi] = (cnt_reg != BUF_FULL);
      assign push                  = request_in[gi].valid & request_ready_out[gi];
      assign eligible[gi]          = (cnt_reg != 2'd0);
      assign pop_buf[gi]           = grant_en & (grant_idx == IDX_W'(gi));
      assign head_payload[gi]      = mem_reg[rd_ptr_reg];

      always_ff @(posedge ap_clk) begin
        if (push) mem_reg[wr_ptr_reg] <= request_in[gi].payload;
      end

      always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
          cnt_reg    <= 2'd0;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
        end else begin
          if (push)        wr_ptr_reg <= ~wr_ptr_reg;
          if (pop_buf[gi]) rd_ptr_reg <= ~rd_ptr_reg;
          case ({push, pop_buf[gi]})
            2'b10:   cnt_reg <= cnt_reg + 2'd1;
            2'b01:   cnt_reg <= cnt_reg - 2'd1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end
    end
  endgenerate

  // Search starts just after the last winner so every requestor waits at most N-1 grants.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_reg;
    cand_idx  = 0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = (int'(last_reg) + k) % N;
      if (!grant_any && eligible[IDX_W'(cand_idx)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand_idx);
      end
    end
  end

  assign grant_en = grant_any & ~fifo_prog_full & ~fifo_setup_reg;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      last_reg          <= IDX_W'(N - 1);
      grant_valid_reg   <= 1'b0;
      grant_payload_reg <= '0;
    end else begin
      grant_valid_reg <= grant_en;
      if (grant_en) begin
        last_reg          <= grant_idx;
        grant_payload_reg <= head_payload[grant_idx];
      end
    end
  end

  // FIFO-side reset: asserted with areset, released on the second edge after it falls.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rst_sync_reg   <= 2'b11;
      fifo_setup_reg <= 1'b1;
    end else begin
      rst_sync_reg   <= {rst_sync_reg[0], 1'b0};
      fifo_setup_reg <= srst;
    end
  end

  assign srst              = rst_sync_reg[1];
  assign fifo_setup_signal = fifo_setup_reg;

  assign fifo_full      = (fifo_count_reg == CNT_DEPTH);
  assign fifo_empty     = (fifo_count_reg == '0);
  assign fifo_prog_full = (fifo_count_reg >= CNT_THRESH);
  assign fifo_wr        = grant_valid_reg & ~fifo_full & ~srst;
  assign fifo_pop       = fifo_request_signals_in.rd_en & ~fifo_empty & ~srst;

  always_ff @(posedge ap_clk) begin
    if (fifo_wr) fifo_mem[fifo_wr_ptr_reg] <= grant_payload_reg;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_count_reg  <= '0;
    end else if (srst) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_count_reg  <= '0;
    end else begin
      if (fifo_wr)  fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 1'b1;
      if (fifo_pop) fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      fifo_request_signals_out <= '{full: 1'b0, prog_full: 1'b0, empty: 1'b1};
      request_out              <= '0;
    end else begin
      fifo_request_signals_out <= '{full: fifo_full, prog_full: fifo_prog_full, empty: fifo_empty};
      request_out.valid        <= fifo_pop;
      if (fifo_pop) request_out.payload <= fifo_mem[fifo_rd_ptr_reg];
    end
  end
endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Randomized bench for the 4-requestor concentrator, checked against
// per-requestor packet queues and the round-robin order rule.
module tb_arbiter_n_to_1_request;
  import arbiter_n_to_1_request_pkg::*;

  localparam int N = 4;

  logic                  ap_clk = 1'b0;
  logic                  areset = 1'b0;
  MemoryPacket           request_in [N];
  logic [N-1:0]          request_ready_out;
  FIFOStateSignalsInput  fifo_in;
  FIFOStateSignalsOutput fifo_out;
  MemoryPacket           request_out;
  logic                  fifo_setup_signal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  MemoryPacketPayload pend_q [N][$];
  MemoryPacketPayload acc_q  [N][$];
  MemoryPacketPayload obs_q  [$];
  int                 obs_cyc [$];

  arbiter_n_to_1_request #(
    .NUM_MEMORY_REQUESTOR(N),
    .BUFFER_DEPTH(2),
    .FIFO_WRITE_DEPTH(32),
    .PROG_THRESH(16)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .request_in(request_in),
    .request_ready_out(request_ready_out),
    .fifo_request_signals_in(fifo_in),
    .fifo_request_signals_out(fifo_out),
    .request_out(request_out),
    .fifo_setup_signal(fifo_setup_signal)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (request_out.valid === 1'b1) begin
      obs_q.push_back(request_out.payload);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic MemoryPacketPayload make_pkt(input int req);
    MemoryPacketPayload p;
    p.meta.route.from = 8'(req);
    p.meta.route.to   = 8'hA5;
    p.meta.cmd        = 4'($urandom);
    p.meta.address    = $urandom;
    p.data            = $urandom;
    return p;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend_q[i].delete();
      acc_q[i].delete();
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      request_in[i].valid   = 1'b0;
      request_in[i].payload = '0;
    end
  endtask

  task automatic do_reset();
    int guard;
    @(posedge ap_clk); #1;
    areset = 1'b1;
    fifo_in.rd_en = 1'b0;
    idle_inputs();
    repeat (3) @(posedge ap_clk);
    #1 areset = 1'b0;
    guard = 0;
    while (fifo_setup_signal !== 1'b0 && guard < 20) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    checks++;
    if (fifo_setup_signal !== 1'b0) begin
      errors++;
      $display("FAIL setup_release: fifo_setup_signal=%b after %0d cycles, required 0", fifo_setup_signal, guard);
    end
    clear_model();
  endtask

  // Presents the head of each enabled requestor's pending queue; a packet is
  // moved to the accepted queue when ready is seen before the accepting edge.
  task automatic drive_step(input logic [N-1:0] en);
    MemoryPacketPayload p;
    @(posedge ap_clk); #1;
    for (int i = 0; i < N; i++) begin
      if (en[i] && pend_q[i].size() > 0) begin
        request_in[i].valid   = 1'b1;
        request_in[i].payload = pend_q[i][0];
        if (request_ready_out[i]) begin
          p = pend_q[i].pop_front();
          acc_q[i].push_back(p);
        end
      end else begin
        request_in[i].valid = 1'b0;
      end
    end
  endtask

  function automatic int pending_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += pend_q[i].size();
    return t;
  endfunction

  function automatic int accepted_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += acc_q[i].size();
    return t;
  endfunction

  task automatic test_reset();
    idle_inputs();
    fifo_in.rd_en = 1'b0;
    #2 areset = 1'b1;
    #1;
    checks++;
    if (request_out.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", request_out.valid);
    end
    checks++;
    if (fifo_setup_signal !== 1'b1) begin
      errors++; $display("FAIL reset_setup: got %b, required 1", fifo_setup_signal);
    end
    checks++;
    if (fifo_out !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got full/prog/empty=%b, required 001", fifo_out);
    end
    checks++;
    if (request_ready_out !== {N{1'b1}}) begin
      errors++; $display("FAIL reset_ready: got %b, required %b", request_ready_out, {N{1'b1}});
    end
    repeat (3) @(posedge ap_clk);
    #1 areset = 1'b0;
    @(posedge ap_clk); #1;
    checks++;
    if (fifo_setup_signal !== 1'b1) begin
      errors++; $display("FAIL setup_hold: got %b one cycle after release, required 1", fifo_setup_signal);
    end
    repeat (6) @(posedge ap_clk);
    #1;
    checks++;
    if (fifo_setup_signal !== 1'b0) begin
      errors++; $display("FAIL setup_clear: got %b, required 0", fifo_setup_signal);
    end
  endtask

  task automatic test_single_latency();
    MemoryPacketPayload p;
    int lat;
    do_reset();
    fifo_in.rd_en = 1'b1;
    p = make_pkt(2);
    @(posedge ap_clk); #1;
    request_in[2].valid   = 1'b1;
    request_in[2].payload = p;
    @(posedge ap_clk); #1;
    request_in[2].valid = 1'b0;
    lat = 1;
    while (request_out.valid !== 1'b1 && lat < 20) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    checks++;
    if (lat > 6) begin
      errors++; $display("FAIL single_latency: valid after %0d cycles, required <= 6", lat);
    end
    checks++;
    if (request_out.payload !== p) begin
      errors++; $display("FAIL single_payload: got %h, required %h", request_out.payload, p);
    end
    repeat (10) @(posedge ap_clk);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL single_count: got %0d packets, required 1", obs_q.size());
    end
  endtask

  task automatic test_fairness();
    MemoryPacketPayload e;
    int guard;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) pend_q[i].push_back(make_pkt(i));
    fifo_in.rd_en = 1'b1;
    guard = 0;
    while (obs_q.size() < 32 && guard < 300) begin
      drive_step('1);
      guard++;
    end
    checks++;
    if (obs_q.size() !== 32) begin
      errors++; $display("FAIL fair_count: got %0d packets, required 32", obs_q.size());
    end else begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (int'(obs_q[k].meta.route.from) !== k % N) begin
          errors++; $display("FAIL fair_order[%0d]: got requestor %0d, required %0d", k, obs_q[k].meta.route.from, k % N);
        end else begin
          e = acc_q[k % N].pop_front();
          checks++;
          if (obs_q[k] !== e) begin
            errors++; $display("FAIL fair_payload[%0d]: got %h, required %h", k, obs_q[k], e);
          end
        end
      end
      checks++;
      if (obs_cyc[31] - obs_cyc[0] !== 31) begin
        errors++; $display("FAIL fair_throughput: 32 packets spanned %0d cycles, required 31", obs_cyc[31] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_partial();
    MemoryPacketPayload e;
    int want, guard;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      pend_q[1].push_back(make_pkt(1));
      pend_q[3].push_back(make_pkt(3));
    end
    fifo_in.rd_en = 1'b1;
    guard = 0;
    while (obs_q.size() < 10 && guard < 200) begin
      drive_step(4'b1010);
      guard++;
    end
    checks++;
    if (obs_q.size() !== 10) begin
      errors++; $display("FAIL partial_count: got %0d packets, required 10", obs_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        want = (k % 2 == 0) ? 1 : 3;
        checks++;
        if (int'(obs_q[k].meta.route.from) !== want) begin
          errors++; $display("FAIL partial_order[%0d]: got requestor %0d, required %0d", k, obs_q[k].meta.route.from, want);
        end else begin
          e = acc_q[want].pop_front();
          checks++;
          if (obs_q[k] !== e) begin
            errors++; $display("FAIL partial_payload[%0d]: got %h, required %h", k, obs_q[k], e);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    MemoryPacketPayload e;
    int guard, nacc;
    logic saw_full;
    do_reset();
    for (int j = 0; j < 40; j++) pend_q[0].push_back(make_pkt(0));
    fifo_in.rd_en = 1'b0;
    saw_full = 1'b0;
    for (int c = 0; c < 80; c++) begin
      drive_step(4'b0001);
      if (fifo_out.full === 1'b1) saw_full = 1'b1;
    end
    nacc = acc_q[0].size();
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL bp_no_output: got %0d packets while rd_en=0, required 0", obs_q.size());
    end
    checks++;
    if (fifo_out.prog_full !== 1'b1) begin
      errors++; $display("FAIL bp_prog_full: got %b, required 1", fifo_out.prog_full);
    end
    checks++;
    if (request_ready_out[0] !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %b, required 0", request_ready_out[0]);
    end
    checks++;
    if (nacc < 18 || nacc > 20) begin
      errors++; $display("FAIL bp_accepted: got %0d accepted, required 18..20 (16 + in-flight + buffer)", nacc);
    end
    fifo_in.rd_en = 1'b1;
    guard = 0;
    while (obs_q.size() < 40 && guard < 400) begin
      drive_step(4'b0001);
      if (fifo_out.full === 1'b1) saw_full = 1'b1;
      guard++;
    end
    checks++;
    if (saw_full !== 1'b0) begin
      errors++; $display("FAIL bp_full: full flag seen %b, required 0", saw_full);
    end
    checks++;
    if (obs_q.size() !== 40) begin
      errors++; $display("FAIL bp_count: got %0d packets, required 40", obs_q.size());
    end else begin
      for (int k = 0; k < 40; k++) begin
        e = acc_q[0].pop_front();
        checks++;
        if (obs_q[k] !== e) begin
          errors++; $display("FAIL bp_payload[%0d]: got %h, required %h", k, obs_q[k], e);
        end
      end
    end
  endtask

  task automatic test_push_at_full();
    MemoryPacketPayload e, drop;
    int guard, total, r;
    do_reset();
    for (int j = 0; j < 20; j++) pend_q[0].push_back(make_pkt(0));
    fifo_in.rd_en = 1'b0;
    repeat (60) drive_step(4'b0001);
    pend_q[1].push_back(make_pkt(1));
    pend_q[1].push_back(make_pkt(1));
    repeat (4) drive_step(4'b0010);
    checks++;
    if (request_ready_out[1] !== 1'b0) begin
      errors++; $display("FAIL drop_ready_before: got %b, required 0", request_ready_out[1]);
    end
    drop = make_pkt(1);
    drop.data = 32'hDEAD_BEEF;
    request_in[1].valid   = 1'b1;
    request_in[1].payload = drop;
    repeat (2) @(posedge ap_clk);
    #1 request_in[1].valid = 1'b0;
    @(posedge ap_clk); #1;
    checks++;
    if (request_ready_out[1] !== 1'b0) begin
      errors++; $display("FAIL drop_ready_after: got %b, required 0 (count stays 2)", request_ready_out[1]);
    end
    fifo_in.rd_en = 1'b1;
    guard = 0;
    while ((pending_total() > 0 || obs_q.size() < accepted_total()) && guard < 400) begin
      drive_step('1);
      guard++;
    end
    repeat (10) @(posedge ap_clk);
    #1;
    total = accepted_total();
    checks++;
    if (obs_q.size() !== total || total !== 22) begin
      errors++; $display("FAIL drop_count: got %0d packets, required %0d (22 accepted)", obs_q.size(), total);
    end
    for (int k = 0; k < obs_q.size(); k++) begin
      r = int'(obs_q[k].meta.route.from);
      checks++;
      if (r >= N || acc_q[r].size() == 0) begin
        errors++; $display("FAIL drop_unexpected[%0d]: got %h, required no packet", k, obs_q[k]);
      end else begin
        e = acc_q[r].pop_front();
        if (obs_q[k] !== e) begin
          errors++; $display("FAIL drop_payload[%0d]: got %h, required %h", k, obs_q[k], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 6; j++) pend_q[i].push_back(make_pkt(i));
    fifo_in.rd_en = 1'b1;
    repeat (10) drive_step('1);
    areset = 1'b1;
    #1;
    checks++;
    if (request_out.valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_valid: got %b, required 0", request_out.valid);
    end
    checks++;
    if (fifo_setup_signal !== 1'b1) begin
      errors++; $display("FAIL mid_reset_setup: got %b, required 1", fifo_setup_signal);
    end
    idle_inputs();
    repeat (3) @(posedge ap_clk);
    #1 areset = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    clear_model();
    repeat (20) @(posedge ap_clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL mid_reset_stale: got %0d packets after reset, required 0", obs_q.size());
    end
    checks++;
    if (request_ready_out !== {N{1'b1}} || fifo_out.empty !== 1'b1) begin
      errors++; $display("FAIL mid_reset_state: ready=%b empty=%b, required %b/1", request_ready_out, fifo_out.empty, {N{1'b1}});
    end
  endtask

  task automatic test_random();
    MemoryPacketPayload e;
    int guard, total, r;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 12; j++) pend_q[i].push_back(make_pkt(i));
    total = 12 * N;
    guard = 0;
    while ((pending_total() > 0 || obs_q.size() < total) && guard < 3000) begin
      drive_step(N'($urandom));
      fifo_in.rd_en = ($urandom_range(0, 3) != 0);
      guard++;
    end
    checks++;
    if (obs_q.size() !== total) begin
      errors++; $display("FAIL rand_count: got %0d packets, required %0d", obs_q.size(), total);
    end
    for (int k = 0; k < obs_q.size(); k++) begin
      r = int'(obs_q[k].meta.route.from);
      checks++;
      if (r >= N || acc_q[r].size() == 0) begin
        errors++; $display("FAIL rand_unexpected[%0d]: got %h, required no packet", k, obs_q[k]);
      end else begin
        e = acc_q[r].pop_front();
        if (obs_q[k] !== e) begin
          errors++; $display("FAIL rand_payload[%0d]: got %h, required %h", k, obs_q[k], e);
        end
      end
    end
  endtask

  initial begin
    fifo_in.rd_en = 1'b0;
    idle_inputs();
    test_reset();
    test_single_latency();
    test_fairness();
    test_partial();
    test_backpressure();
    test_push_at_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arbiter_n_to_1_request.md
# arbiter_N_to_1_request

Round-robin concentrator that merges `MemoryPacket` requests from `NUM_MEMORY_REQUESTOR` requestors into one request stream toward the memory/cache port. Each requestor gets a 2-entry holding buffer with a ready signal. A fair grant moves one packet per cycle into a 32-deep FWFT output FIFO, which the downstream consumer pops through the standard FIFO state-signal handshake. The block is the request-side counterpart of the 1-to-N response demux. Requestors must populate `payload.meta.route.from` so that responses route back correctly; this block passes the payload through unmodified.

## Interface
**Parameters**
- `NUM_MEMORY_REQUESTOR`, 2: number of requestor ports, ≥1.
- `BUFFER_DEPTH`, 2: per-requestor holding buffer entries, fixed at 2.
- `FIFO_WRITE_DEPTH`, 32: output FIFO depth.
- `PROG_THRESH`, 16: output FIFO prog_full threshold.

**Ports**
- `ap_clk`, in, 1: clock.
- `areset`, in, 1: reset; one clock, reset asynchronous and active-high.
- `request_in`, in, `MemoryPacket[N]`: requestor packets; `.valid` qualifies.
- `request_ready_out`, out, `[N]`: requestor may assert `.valid` this cycle.
- `fifo_request_signals_in`, in, `FIFOStateSignalsInput`: downstream `.rd_en`.
- `fifo_request_signals_out`, out, `FIFOStateSignalsOutput`: output FIFO flags, registered.
- `request_out`, out, `MemoryPacket`: merged request, registered.
- `fifo_setup_signal`, out, 1: high while resetting or FIFO reset-busy.

## Operation
- **Holding buffer i:**
  - 2-entry FIFO of `MemoryPacketPayload` with count register `cnt[i]` in 0..2.
  - `request_ready_out[i] = (cnt[i] != 2)`, combinational from the register.
  - Push = `request_in[i].valid & request_ready_out[i]`.
  - A `.valid` while not ready is dropped and must not corrupt the buffer.
- **Eligibility:** requestor i is eligible when `cnt[i] != 0`.
- **Grant conditions:**
  - At most one grant per cycle.
  - A grant is issued only if the output FIFO `prog_full` = 0 and `fifo_setup_signal` = 0.
- **Round-robin:**
  - Pointer `last` holds the index of the last granted requestor.
  - The next grant goes to the first eligible index in order last+1, last+2, …, wrapping modulo N.
  - `last` updates only on a grant.
  - Reset value of `last` is N-1, so requestor 0 has first priority after reset.
- **Grant effect:**
  - Pops the head of buffer i.
  - Loads `grant_payload_reg` and sets `grant_valid_reg` at the clock edge.
  - On the next cycle, `grant_valid_reg` drives the FIFO `wr_en` and `grant_payload_reg` drives `din`.
- **Simultaneous push and grant on the same buffer:**
  - Count is unchanged.
  - Packet order within a requestor is strictly preserved.
- **Output FIFO:** `xpm_fifo_sync_wrapper`, FWFT, width `$bits(MemoryPacketPayload)`.
  - Pop = `fifo_request_signals_in.rd_en & ~empty`.
  - `request_out.valid` is registered from `fifo.valid & pop`.
  - `request_out.payload` is registered from `dout`.
- **Headroom:** the prog_full gate at 16 leaves room for in-flight writes, so `full` is never reached by design.

## Timing
- **Reset values:**
  - `areset` asynchronously clears: all `cnt`, `grant_valid_reg`, and `request_out.valid`; `fifo_setup_signal` is set to 1.
  - `last` is set to N-1.
  - `fifo_request_signals_out` is set to all-zero except `empty` = 1.
  - `request_ready_out` is therefore all-1, but requestors must wait for `fifo_setup_signal` = 0.
- **FIFO reset:**
  - FIFO `srst` is a reset-synchronised copy of `areset`: asserted asynchronously, deasserted on the 2nd `ap_clk` edge after `areset` falls.
  - `fifo_setup_signal` is registered: (`wr_rst_busy` | `rd_rst_busy`).
- **Reset mid-operation:** all buffered and in-flight packets are discarded and no partial packet appears on `request_out`.
- **Latency, idle block:**
  - Request accepted at edge E0; granted in cycle E0→E1; `wr_en` in cycle E1→E2.
  - `request_out.valid` is high at edge E2 + FWFT latency + 1, and no later than E0 + 6 given `rd_en` held high.
- **Throughput:** with all requestors backlogged and consumer `rd_en` = 1, the block sustains 1 packet per cycle.
- **Fairness:** with N requestors continuously eligible, each is granted exactly once in every N consecutive grants.
- **Backpressure:**
  - `rd_en` = 0 fills the FIFO until `prog_full`; grants then stop.
  - Buffers fill to 2 and `request_ready_out` drops the cycle after `cnt` reaches 2.

## Test plan
- **Reset:** assert `areset` mid-traffic for 3 cycles → `request_out.valid` = 0 immediately, `fifo_setup_signal` = 1 until FIFO busy clears, no stale packets afterwards.
- **Fairness:** N = 4, all four requestors push 8 packets each back-to-back, `rd_en` = 1 → output order 0,1,2,3 repeating, 32 packets, sustained 1 packet per cycle once the pipeline is full.
- **Partial eligibility:** N = 4, only requestors 1 and 3 active with 5 packets each → strict alternation 1,3,1,3,… and per-requestor payload order preserved.
- **Backpressure:** hold `rd_en` = 0, push 40 packets from requestor 0 → FIFO stops at 16 plus in-flight writes with `full` never asserted, `request_ready_out[0]` falls, then drain → exactly 40 packets in order.
- **Single request latency:** single packet on requestor 2 with the block idle → `request_out.valid` ≤ 6 cycles later, with payload bit-identical to the input.
- **Push at buffer full:** drive `request_in[1].valid` while `cnt[1]` = 2 → packet dropped, `cnt[1]` stays 2, the two stored packets are delivered unchanged.
